// File: rtl/pagerank_host_driver.sv
// Host-side job driver: writes scheduler regs 1,2,3 then start (reg 0), polls until done or poll limit.
// Latency: 8 cycles of config traffic after cfg fire, then POLL_GAP+3 cycles per poll with a zero-stall responder.
// Backpressure: one request in flight; req_rdy=0 or resp_val=0 holds state and outputs unchanged.
module pagerank_host_driver #(
    parameter int nbits     = 32,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_val,
    output logic               cfg_rdy,
    input  logic [nbits-1:0]   cfg_base_g,
    input  logic [nbits-1:0]   cfg_base_r,
    input  logic [nbits-1:0]   cfg_size,
    output logic [2*nbits:0]   req_msg,
    output logic               req_val,
    input  logic               req_rdy,
    input  logic [nbits:0]     resp_msg,
    input  logic               resp_val,
    output logic               resp_rdy,
    output logic               done,
    output logic               busy,
    output logic               timeout,
    output logic               err,
    output logic [31:0]        poll_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_GAP,
        S_RD_REQ,
        S_RD_RESP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [nbits-1:0]   base_g;
    logic [nbits-1:0]   base_r;
    logic [nbits-1:0]   size_q;
    logic [1:0]         idx;
    logic [31:0]        gap_cnt;
    logic [nbits-1:0]   wdata;

    logic               cfg_fire;
    logic               resp_fire;
    logic               resp_type;
    logic               poll_hit;
    logic               last_poll;

    assign cfg_fire  = cfg_val && cfg_rdy;
    assign resp_fire = resp_val && resp_rdy;
    assign resp_type = resp_msg[nbits];
    // Anything other than exactly 1 in the data field means "still running".
    assign poll_hit  = (resp_msg[nbits-1:0] == nbits'(1));
    assign last_poll = ((poll_count + 32'd1) == 32'(MAX_POLLS));

    always_comb begin
        wdata = '0;
        case (idx)
            2'd1:    wdata = base_g;
            2'd2:    wdata = base_r;
            2'd3:    wdata = size_q;
            default: wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cfg_rdy    = 1'b0;
        req_val    = 1'b0;
        req_msg    = '0;
        resp_rdy   = 1'b0;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_val) begin
                    state_next = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                req_val = 1'b1;
                req_msg = {1'b1, {{(nbits-2){1'b0}}, idx}, wdata};
                if (req_rdy) begin
                    state_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                resp_rdy = 1'b1;
                if (resp_val) begin
                    state_next = (idx == 2'd0) ? S_GAP : S_WR_REQ;
                end
            end
            S_GAP: begin
                if (gap_cnt == 32'd0) begin
                    state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                req_val = 1'b1;
                if (req_rdy) begin
                    state_next = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                resp_rdy = 1'b1;
                if (resp_val) begin
                    state_next = (poll_hit || last_poll) ? S_DONE : S_GAP;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_g     <= '0;
            base_r     <= '0;
            size_q     <= '0;
            idx        <= 2'd0;
            gap_cnt    <= 32'd0;
            poll_count <= 32'd0;
            timeout    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == S_IDLE && cfg_fire) begin
                base_g     <= cfg_base_g;
                base_r     <= cfg_base_r;
                size_q     <= cfg_size;
                idx        <= 2'd1;
                poll_count <= 32'd0;
                timeout    <= 1'b0;
                err        <= 1'b0;
            end
            if (state == S_WR_RESP && resp_fire) begin
                if (resp_type != 1'b1) begin
                    err <= 1'b1;
                end
                // idx walks 1->2->3->0; the start write (idx 0) is the last one.
                idx <= idx + 2'd1;
                if (idx == 2'd0) begin
                    gap_cnt <= 32'(POLL_GAP);
                end
            end
            if (state == S_GAP && gap_cnt != 32'd0) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
            if (state == S_RD_RESP && resp_fire) begin
                poll_count <= poll_count + 32'd1;
                if (resp_type != 1'b0) begin
                    err <= 1'b1;
                end
                if (!poll_hit) begin
                    if (last_poll) begin
                        timeout <= 1'b1;
                    end else begin
                        gap_cnt <= 32'(POLL_GAP);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pagerank_host_driver.sv
// Scoreboarded bench for pagerank_host_driver: expected requests queued per job, checked on each request fire.
module tb_pagerank_host_driver;

    localparam int G  = 2;
    localparam int MP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [31:0] cfg_base_g;
    logic [31:0] cfg_base_r;
    logic [31:0] cfg_size;
    logic [64:0] req_msg;
    logic        req_val;
    logic        req_rdy;
    logic [32:0] resp_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic        done;
    logic        busy;
    logic        timeout;
    logic        err;
    logic [31:0] poll_count;

    always #5 clk = ~clk;

    pagerank_host_driver #(
        .nbits    (32),
        .POLL_GAP (G),
        .MAX_POLLS(MP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_val   (cfg_val),
        .cfg_rdy   (cfg_rdy),
        .cfg_base_g(cfg_base_g),
        .cfg_base_r(cfg_base_r),
        .cfg_size  (cfg_size),
        .req_msg   (req_msg),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .resp_msg  (resp_msg),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .done      (done),
        .busy      (busy),
        .timeout   (timeout),
        .err       (err),
        .poll_count(poll_count)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [64:0] exp_q[$];
    logic [32:0] resp_q[$];
    logic [31:0] polls[$];
    int          rd_cyc[$];

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Request monitor / zero-stall responder.
    initial begin
        logic rf;
        resp_val = 1'b0;
        resp_msg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rf = resp_val && resp_rdy;
            if (req_val && req_rdy && !reset) begin
                chk("req_pending", (exp_q.size() != 0) ? 65'd1 : 65'd0, 65'd1);
                if (exp_q.size() != 0) chk("req_msg", req_msg, exp_q.pop_front());
                if (!req_msg[64]) rd_cyc.push_back(cyc);
            end
            @(posedge clk);
            #2;
            if (rf && resp_q.size() != 0) void'(resp_q.pop_front());
            resp_val = (resp_q.size() != 0);
            resp_msg = resp_val ? resp_q[0] : 33'd0;
        end
    end

    task automatic run_job(input logic [31:0] g, input logic [31:0] r, input logic [31:0] s,
                           input int bad_wr, input bit stall, input int reset_at,
                           input int exp_pc, input bit exp_to, input int exp_done);
        int n;
        bit finished;
        bit saw_done;
        int dn;
        finished = 0;
        saw_done = 0;
        dn = -1;
        rd_cyc.delete();
        exp_q.push_back({1'b1, 32'd1, g});
        exp_q.push_back({1'b1, 32'd2, r});
        exp_q.push_back({1'b1, 32'd3, s});
        exp_q.push_back({1'b1, 32'd0, 32'd0});
        foreach (polls[i]) exp_q.push_back(65'd0);
        for (int i = 0; i < 4; i++) resp_q.push_back({(i == bad_wr) ? 1'b0 : 1'b1, 32'd0});
        foreach (polls[i]) resp_q.push_back({1'b0, polls[i]});

        @(posedge clk);
        #1;
        cfg_val    = 1'b1;
        cfg_base_g = g;
        cfg_base_r = r;
        cfg_size   = s;
        n = 0;
        while (n < 100 && !finished) begin
            @(negedge clk);
            if (n == 0) chk("cfg_rdy_idle", 65'(cfg_rdy), 65'd1);
            if (n == 1) begin
                chk("busy_started", 65'(busy), 65'd1);
                chk("err_cleared", 65'(err), 65'd0);
                chk("timeout_cleared", 65'(timeout), 65'd0);
                chk("pc_cleared", 65'(poll_count), 65'd0);
            end
            if (stall && n >= 3 && n <= 7) begin
                chk("bp_val", 65'(req_val), 65'd1);
                chk("bp_msg", req_msg, {1'b1, 32'd2, r});
            end
            if (reset_at >= 0) begin
                if (done) saw_done = 1;
                if (n == reset_at) chk("rst_in_rdresp", 65'(resp_rdy), 65'd1);
                if (n == reset_at + 1) begin
                    chk("rst_busy", 65'(busy), 65'd0);
                    chk("rst_cfg_rdy", 65'(cfg_rdy), 65'd1);
                    finished = 1;
                end
            end else if (done) begin
                dn = n;
                finished = 1;
                chk("done_cycle", 65'(dn), 65'(exp_done));
                chk("timeout", 65'(timeout), 65'(exp_to));
                chk("err", 65'(err), (bad_wr >= 0) ? 65'd1 : 65'd0);
                chk("poll_count", 65'(poll_count), 65'(exp_pc));
            end
            @(posedge clk);
            #1;
            // Cfg presented mid-job must be ignored.
            cfg_val    = (n == 4);
            cfg_base_g = 32'hdead_0000;
            cfg_base_r = 32'hdead_0001;
            cfg_size   = 32'hdead_0002;
            req_rdy    = !(stall && n + 1 >= 3 && n + 1 <= 7);
            reset      = (reset_at >= 0 && n + 1 == reset_at);
            n++;
        end
        if (!finished) chk("done_seen", 65'(done), 65'd1);

        if (reset_at >= 0) begin
            repeat (8) begin
                @(negedge clk);
                if (done) saw_done = 1;
            end
            chk("no_done_after_reset", 65'(saw_done), 65'd0);
            exp_q.delete();
            resp_q.delete();
        end else begin
            @(negedge clk);
            chk("done_pulse_len", 65'(done), 65'd0);
            chk("idle_busy", 65'(busy), 65'd0);
            chk("pc_hold", 65'(poll_count), 65'(exp_pc));
            chk("req_q_drained", 65'(exp_q.size()), 65'd0);
            chk("rd_count", 65'(rd_cyc.size()), 65'(polls.size()));
            for (int i = 1; i < rd_cyc.size(); i++)
                chk("rd_spacing", 65'(rd_cyc[i] - rd_cyc[i-1]), 65'(G + 3));
        end
    endtask

    initial begin
        reset      = 1'b1;
        cfg_val    = 1'b0;
        cfg_base_g = '0;
        cfg_base_r = '0;
        cfg_size   = '0;
        req_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cfg_rdy", 65'(cfg_rdy), 65'd1);
        chk("rst_req_val", 65'(req_val), 65'd0);
        chk("rst_resp_rdy", 65'(resp_rdy), 65'd0);
        chk("rst_done", 65'(done), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_timeout", 65'(timeout), 65'd0);
        chk("rst_err", 65'(err), 65'd0);
        chk("rst_poll_count", 65'(poll_count), 65'd0);
        chk("rst_req_msg", req_msg, 65'd0);

        // done cycle = 12 + G + (polls-1)*(G+3) + stall cycles
        polls = '{32'd1};
        run_job(32'h1000, 32'h2000, 32'd8, -1, 1'b0, -1, 1, 1'b0, 14);
        polls = '{32'd0, 32'd0, 32'd1};
        run_job(32'h1100, 32'h2100, 32'd16, -1, 1'b0, -1, 3, 1'b0, 24);
        polls = '{32'd0, 32'd0, 32'd0};
        run_job(32'h1200, 32'h2200, 32'd4, -1, 1'b0, -1, 3, 1'b1, 24);
        polls = '{32'd2, 32'd1};
        run_job(32'h1300, 32'h2300, 32'd5, -1, 1'b0, -1, 2, 1'b0, 19);
        polls = '{32'd1};
        run_job(32'h1000, 32'h2000, 32'd8, -1, 1'b1, -1, 1, 1'b0, 19);
        polls = '{32'd1};
        run_job(32'h1400, 32'h2400, 32'd9, 1, 1'b0, -1, 1, 1'b0, 14);
        polls = '{32'd1};
        run_job(32'h1500, 32'h2500, 32'd10, -1, 1'b0, -1, 1, 1'b0, 14);
        polls = '{32'd0, 32'd0, 32'd1};
        run_job(32'h1600, 32'h2600, 32'd11, -1, 1'b0, 13, 0, 1'b0, 0);
        polls = '{32'd0, 32'd1};
        run_job(32'h1700, 32'h2700, 32'd12, -1, 1'b0, -1, 2, 1'b0, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1);
    end

endmodule
